// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared types and constants for the LED matrix scanner: grid geometry, row
// index and frame types, the scan FSM state encoding and a small helper used
// to size the shared dwell/blank counter.
// Optional feature macro used by this slice: SCAN_PWM_EN (see top module).
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 8;

  typedef logic [2:0] row_idx_t;
  // frame[r] holds the column bits of row r
  typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BLANK = 2'd2,
    SHOW  = 2'd3
  } scan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Loadable down-counter shared by the BLANK and SHOW phases. A load sets the
// count to (phase length - 1); the counter then decrements once per cycle and
// parks at zero. o_done is high while the count is zero, i.e. in the last
// cycle of the phase.
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_load      load i_load_val this cycle (takes priority over counting)
//   i_load_val  value to load
//   o_done      count has reached zero
// -----------------------------------------------------------------------------
module dwell_timer #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// led_matrix_scanner
// Time-multiplexes an 8x8 lights frame onto a physical LED matrix one row at a
// time. The frame is snapshotted in the LOAD cycle at each frame boundary, so
// edits made while a frame is being scanned only appear in the next frame.
// Each row gets BLANK_CYCLES dark cycles (anti-ghosting) followed by
// DWELL_CYCLES lit cycles. All outputs are registered.
//
// Optional feature: define SCAN_PWM_EN to add the i_brightness port. Within
// each SHOW phase the columns are then lit only while (elapsed SHOW cycles
// mod 8) <= brightness; brightness is sampled in LOAD and held for the frame.
// DWELL_CYCLES must be a multiple of 8 in that build.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_enable       1 = scan, 0 = matrix dark and FSM parked in IDLE
//   i_lights       frame to display, i_lights[r] = columns of row r
//   i_brightness   (SCAN_PWM_EN only) 0 = 1/8 duty .. 7 = full
//   o_row_drive    one-hot active-high row select, 0 when no row is lit
//   o_col_drive    column data of the lit row, 0 when no row is lit
//   o_frame_start  1-cycle pulse during the LOAD cycle
//   o_debug        current row index
// -----------------------------------------------------------------------------
module led_matrix_scanner
  import scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  frame_t              i_lights,
`ifdef SCAN_PWM_EN
  input  logic [2:0]          i_brightness,
`endif
  output logic [NUM_ROWS-1:0] o_row_drive,
  output logic [NUM_COLS-1:0] o_col_drive,
  output logic                o_frame_start,
  output row_idx_t            o_debug
);

  localparam int CNT_W = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t         r_state;
  row_idx_t            r_row;
  frame_t              r_frame_buf;
  logic [NUM_ROWS-1:0] r_row_drive;
  logic [NUM_COLS-1:0] r_col_drive;
  logic                r_frame_start;

  logic                w_done;
  logic                w_tmr_load;
  logic [CNT_W-1:0]    w_tmr_val;
  logic [NUM_COLS-1:0] w_show_cols;

`ifdef SCAN_PWM_EN
  logic [2:0] r_bright;
  logic [2:0] r_pwm_phase;   // elapsed SHOW cycles mod 8
  logic [2:0] w_phase_next;
`endif

  // The timer is reloaded on every entry into BLANK or SHOW; IDLE and LOAD
  // do not use it.
  assign w_tmr_load = i_enable &&
                      ((r_state == LOAD) ||
                       (r_state == BLANK && w_done) ||
                       (r_state == SHOW && w_done && r_row != row_idx_t'(NUM_ROWS - 1)));
  assign w_tmr_val  = (r_state == BLANK) ? DWELL_LOAD : BLANK_LOAD;

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_done)
  );

  // Column value to present in the SHOW cycle that follows this edge.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_show_cols = r_frame_buf[r_row];
`ifdef SCAN_PWM_EN
    w_phase_next = (r_state == SHOW) ? r_pwm_phase + 3'd1 : 3'd0;
    if (w_phase_next > r_bright) begin
      w_show_cols = '0;
    end
`endif
  end

  // NOTE: the frame buffer is a plain register bank (not a RAM), and a
  // cleared frame after reset is required behaviour, so it is reset too.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_row         <= '0;
      r_frame_buf   <= '0;
      r_row_drive   <= '0;
      r_col_drive   <= '0;
      r_frame_start <= 1'b0;
`ifdef SCAN_PWM_EN
      r_bright      <= '0;
      r_pwm_phase   <= '0;
`endif
    end else if (!i_enable) begin
      r_state       <= IDLE;
      r_row         <= '0;
      r_row_drive   <= '0;
      r_col_drive   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state       <= LOAD;
          r_frame_start <= 1'b1;
        end
        LOAD: begin
          r_frame_buf   <= i_lights;
          r_row         <= '0;
          r_frame_start <= 1'b0;
          r_state       <= BLANK;
`ifdef SCAN_PWM_EN
          r_bright      <= i_brightness;
`endif
        end
        BLANK: begin
          if (w_done) begin
            r_state     <= SHOW;
            r_row_drive <= NUM_ROWS'(1) << r_row;
            r_col_drive <= w_show_cols;
`ifdef SCAN_PWM_EN
            r_pwm_phase <= w_phase_next;
`endif
          end
        end
        SHOW: begin
          if (w_done) begin
            r_row_drive <= '0;
            r_col_drive <= '0;
            if (r_row == row_idx_t'(NUM_ROWS - 1)) begin
              r_state       <= LOAD;
              r_frame_start <= 1'b1;
            end else begin
              r_row   <= r_row + row_idx_t'(1);
              r_state <= BLANK;
            end
          end else begin
            r_col_drive <= w_show_cols;
`ifdef SCAN_PWM_EN
            r_pwm_phase <= w_phase_next;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_row_drive   = r_row_drive;
  assign o_col_drive   = r_col_drive;
  assign o_frame_start = r_frame_start;
  assign o_debug       = r_row;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scanner
// Self-checking bench for led_matrix_scanner. A behavioural model tracks the
// cycle position inside the frame (0 = LOAD) and derives row, blank/show and
// expected pins arithmetically from the frame period.
// Builds with or without SCAN_PWM_EN.
// -----------------------------------------------------------------------------
module tb_led_matrix_scanner;
  import scan_pkg::*;

`ifdef SCAN_PWM_EN
  localparam int DW = 8;
`else
  localparam int DW = 4;
`endif
  localparam int BL     = 2;
  localparam int SLOT   = BL + DW;
  localparam int PERIOD = 1 + NUM_ROWS * SLOT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  frame_t     lights;
  logic [2:0] bright;
  logic [7:0] row_drive;
  logic [7:0] col_drive;
  logic       frame_start;
  row_idx_t   debug;

  always #5 clk = ~clk;

  led_matrix_scanner #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (en),
    .i_lights      (lights),
`ifdef SCAN_PWM_EN
    .i_brightness  (bright),
`endif
    .o_row_drive   (row_drive),
    .o_col_drive   (col_drive),
    .o_frame_start (frame_start),
    .o_debug       (debug)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_active = 1'b0;
  int         m_k      = 0;      // cycles since LOAD
  logic [7:0] m_snap [NUM_ROWS];
  int         m_bright = 7;
  int         cyc      = 0;
  int         last_fs  = -1;

  function automatic int m_row();
    return (m_k - 1) / SLOT;
  endfunction

  function automatic bit m_in_show();
    return m_active && (m_k > 0) && (((m_k - 1) % SLOT) >= BL);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    foreach (m_snap[r]) m_snap[r] = 8'h00;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else if (!en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_k      = 0;
    end else begin
      if (m_k == 0) begin
        for (int r = 0; r < NUM_ROWS; r++) m_snap[r] = lights[r];
`ifdef SCAN_PWM_EN
        m_bright = int'(bright);
`endif
      end
      m_k = (m_k + 1) % PERIOD;
    end
  endtask

  task automatic compare();
    logic [7:0] e_row, e_col;
    logic       e_fs;
    int         row, off, el;
    e_row = 8'h00;
    e_col = 8'h00;
    e_fs  = 1'b0;
    if (!m_active) begin
      check("idle_debug", 32'(debug), 32'd0);
      last_fs = -1;
    end else if (m_k == 0) begin
      e_fs = 1'b1;
    end else begin
      row = m_row();
      off = (m_k - 1) % SLOT;
      if (off >= BL) begin
        el    = off - BL;
        e_row = 8'h01 << row;
        e_col = ((el % 8) <= m_bright) ? m_snap[row] : 8'h00;
      end
      check("debug", 32'(debug), 32'(row));
    end
    check("row_drive", 32'(row_drive), 32'(e_row));
    check("col_drive", 32'(col_drive), 32'(e_col));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(PERIOD));
      last_fs = cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model sits at frame position k (bounded).
  task automatic wait_k(input int k);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      tick();
      if (m_active && m_k == k) found = 1'b1;
    end
    check("wait_k_timeout", 32'(found), 32'd1);
  endtask

  function automatic int show_k(input int row, input int el);
    return 1 + row * SLOT + BL + el;
  endfunction

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    lights = '0;
    bright = 3'd7;
    model_reset();

    // Reset held with enable high: everything dark.
    ticks(3);
    check("reset_fbuf", 32'(|dut.r_frame_buf), 32'd0);

    // Diagonal pattern; release reset -> LOAD next edge.
    for (int r = 0; r < NUM_ROWS; r++) lights[r] = 8'h01 << r;
    rst_n = 1'b1;
    tick();
    check("first_load_fs", 32'(frame_start), 32'd1);

    // Edit row 3 while row 1 is on screen; row 3 must keep old data this frame.
    wait_k(show_k(1, 0));
    lights[3] = 8'hFF;
    wait_k(show_k(3, 0));
    check("row3_old_frame", 32'(col_drive), 32'h08);
    wait_k(show_k(3, 0));
    check("row3_new_frame", 32'(col_drive), 32'hFF);

    // Drop enable in SHOW of row 5, then restart from row 0.
    wait_k(show_k(5, 1));
    en = 1'b0;
    tick();
    check("disable_rows", 32'(row_drive), 32'd0);
    ticks(2);
    en = 1'b1;
    tick();
    check("reenable_fs", 32'(frame_start), 32'd1);
    wait_k(show_k(0, 0));
    check("restart_row0", 32'(row_drive), 32'h01);
    ticks(PERIOD);

    // Asynchronous reset in the middle of a SHOW phase.
    wait_k(show_k(2, 1));
    #2 rst_n = 1'b0;
    #1;
    check("async_row", 32'(row_drive), 32'd0);
    check("async_col", 32'(col_drive), 32'd0);
    check("async_debug", 32'(debug), 32'd0);
    check("async_fbuf", 32'(|dut.r_frame_buf), 32'd0);
    model_reset();
    ticks(2);
    rst_n = 1'b1;

`ifdef SCAN_PWM_EN
    // Brightness 3 on row 0 = 8'hAA: 4 of 8 SHOW cycles lit, row held all 8.
    begin
      int lit, rows_on;
      lit = 0;
      rows_on = 0;
      en = 1'b0;
      tick();
      lights = '0;
      lights[0] = 8'hAA;
      bright = 3'd3;
      en = 1'b1;
      wait_k(show_k(0, 0));
      for (int i = 0; i < DW; i++) begin
        if (col_drive == 8'hAA) lit++;
        if (row_drive == 8'h01) rows_on++;
        if (i != DW - 1) tick();
      end
      check("pwm_lit_cycles", 32'(lit), 32'd4);
      check("pwm_row_cycles", 32'(rows_on), 32'(DW));
    end
`endif

    // Randomized run: random frames, brightness, mid-frame edits and enable drops.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int r = 0; r < NUM_ROWS; r++) lights[r] = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0) bright = 3'($urandom);
      if ($urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
